sub_16b_seq: RTL and testbench
==============================

Name: sub_16b_seq

Overview:
- Multi-cycle 16-bit subtractor: D = A - B - Bin, computed one DIGIT-wide slice per clock, LSB slice first.
- The borrow between slices is held in a register.
- Valid/ready handshake on both input and output; sits beside the ALU's combinational adder path for low-area subtract/compare.
- Produces unsigned borrow, signed overflow and zero flags.

Parameters:
- DIGIT, 4, bits processed per cycle; legal values 4, 8, 16; STEPS = 16/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- A  input  16  minuend
- B  input  16  subtrahend
- B_in  input  1  borrow in (1 = subtract one more)
- D  output  16  difference
- B_out  output  1  borrow out; 1 when A < B + B_in (unsigned)
- Ofl  output  1  signed two's-complement overflow
- Zero  output  1  D == 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result

Behaviour:
- Reset (rst == 0 at a rising edge):
  - State goes to IDLE; out_valid = 0; D = 0x0000; B_out = 0; Ofl = 0; Zero = 0; slice index = 0.
  - Reset overrides everything, including mid-CALC; a partial result is discarded and never presented.
- in_ready = 1 in IDLE, or in DONE while out_ready = 1; otherwise 0 (combinational).
- Accept: when in_valid & in_ready at an edge, register A, B and B_in. Borrow register = B_in, slice index = 0, go to CALC.
- Operand inputs are ignored outside an accept edge.
- CALC, per edge:
  - Slice k: D[k*DIGIT +: DIGIT] = A_slice + ~B_slice + ~borrow (carry form). New borrow = ~carry_out.
  - Increment k. On the edge that completes slice STEPS-1, go to DONE.
- Flags are set on the final slice edge:
  - B_out = final borrow.
  - Ofl = (A[15] != B[15]) & (D[15] != A[15]).
  - Zero = (D == 0).
- Latency: out_valid rises STEPS cycles after the accept edge (4 for DIGIT=4; 1 for DIGIT=16).
- DONE: out_valid = 1. D and flags stay stable while out_ready = 0.
- On out_valid & out_ready at an edge:
  - With in_valid = 1 in the same cycle, accept new operands and go straight to CALC (back-to-back, no IDLE bubble).
  - Otherwise go to IDLE. out_valid drops; D and flags hold their last value.
- D may show partially updated slices during CALC. Consumers sample only when out_valid = 1.
- in_valid while busy (CALC, or DONE without out_ready) is not consumed; the producer must hold it.
- Wrap-around: D is modulo 2^16. 0x0000 - 0x0001 gives 0xFFFF with B_out = 1.

Optional Feature:
- Macro SUB16_SAT_EN.
- Defined: when Ofl = 1, D is clamped to the signed limit: 0x7FFF if A[15] = 0, 0x8000 if A[15] = 1. Zero is computed on the clamped value; B_out and Ofl are unchanged. The clamp is applied on the final slice edge.
- Undefined: D wraps modulo 2^16 and no clamp logic is present.

Test Plan:
- A=0x1234, B=0x0234, B_in=0, DIGIT=4 -> out_valid exactly 4 cycles after accept; D=0x1000, B_out=0, Ofl=0, Zero=0.
- A=0x0000, B=0x0001 -> D=0xFFFF, B_out=1, Ofl=0. A=0x0005, B=0x0005, B_in=1 -> D=0xFFFF, B_out=1. A=0x5A5A, B=0x5A5A -> D=0x0000, Zero=1.
- A=0x8000, B=0x0001 -> Ofl=1, B_out=0; D=0x7FFF without SUB16_SAT_EN, D=0x8000 with it. A=0x7FFF, B=0xFFFF -> Ofl=1, B_out=1; D=0x8000 wrapped, 0x7FFF saturated.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> D and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (A=0x0010, B=0x0001) -> accepted that edge; next result D=0x000F after 4 cycles.
- Drive rst=0 for one edge during the 2nd CALC cycle -> next cycle: IDLE, out_valid=0, D=0x0000, in_ready=1; no result is emitted.
- Repeat the first and third scenarios with DIGIT=8 and DIGIT=16 -> latency 2 and 1 cycles; results identical.

Source files
------------

// File: rtl/sub_16b_seq.sv
// -----------------------------------------------------------------------------
// sub_16b_seq
//
// Multi-cycle 16-bit subtractor: D = A - B - B_in.
// The datapath handles one DIGIT-wide slice per clock, least significant
// slice first. The borrow between slices is kept in a register. This block
// sits beside the ALU's combinational adder and gives a low-area subtract or
// compare.
//
// Parameter:
//   DIGIT        bits per cycle. Legal values are 4, 8 and 16.
//                STEPS = 16/DIGIT.
//
// Optional feature:
//   SUB16_SAT_EN When this macro is defined, a signed overflow clamps D to
//                0x7FFF or 0x8000. The clamp is applied on the final slice.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   in_valid     operands valid
//   in_ready     block can accept operands (combinational)
//   A, B, B_in   minuend, subtrahend, borrow in
//   D            difference. Slices may be partially updated during CALC.
//   B_out        unsigned borrow out (A < B + B_in)
//   Ofl          signed two's-complement overflow
//   Zero         D == 0
//   out_valid    result valid (DONE state)
//   out_ready    consumer accepts result
//   dbg_state_o  current FSM state, for debug and checker binding
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid must keep its data stable until that edge.
// in_valid that arrives while the block is busy is left unconsumed.
// -----------------------------------------------------------------------------
module sub_16b_seq #(
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        B_in,
  output logic [15:0] D,
  output logic        B_out,
  output logic        Ofl,
  output logic        Zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state_o
);

  localparam int STEPS = 16 / DIGIT;
  // With one step the slice index still needs one bit. That bit is always 0.
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      d_q, d_d;
  logic             bout_q, bout_d;
  logic             ofl_q, ofl_d;
  logic             zero_q, zero_d;

  // Slice datapath
  int unsigned      base;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT:0]   sum;
  logic [15:0]      d_calc;
  logic [15:0]      d_fin;
  logic             ofl_calc;
  logic             is_last;
  logic             accept;

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid   = (state_q == S_DONE);
  assign accept      = in_valid && in_ready;
  assign is_last     = (idx_q == LAST_IDX);
  assign dbg_state_o = state_q;

  assign D     = d_q;
  assign B_out = bout_q;
  assign Ofl   = ofl_q;
  assign Zero  = zero_q;

  // The subtraction is done as A + ~B + ~borrow. A carry out of the slice
  // means that no borrow is needed for the next slice.
  always_comb begin
    base     = 0;
    slice_a  = '0;
    slice_b  = '0;
    sum      = '0;
    d_calc   = d_q;
    d_fin    = d_q;
    ofl_calc = 1'b0;

    base    = int'(idx_q) * DIGIT;
    slice_a = a_q[base +: DIGIT];
    slice_b = b_q[base +: DIGIT];
    sum     = {1'b0, slice_a} + {1'b0, ~slice_b} + {{DIGIT{1'b0}}, ~borrow_q};
    d_calc[base +: DIGIT] = sum[DIGIT-1:0];

    // Only meaningful on the last slice, once d_calc[15] is final.
    ofl_calc = (a_q[15] != b_q[15]) && (d_calc[15] != a_q[15]);
    d_fin    = d_calc;
`ifdef SUB16_SAT_EN
    if (ofl_calc) begin
      d_fin = a_q[15] ? 16'h8000 : 16'h7FFF;
    end
`endif
  end

  // Next-state and register-load logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    d_d      = d_q;
    bout_d   = bout_q;
    ofl_d    = ofl_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = A;
          b_d      = B;
          borrow_d = B_in;
          idx_d    = '0;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        borrow_d = ~sum[DIGIT];
        if (is_last) begin
          d_d     = d_fin;
          bout_d  = ~sum[DIGIT];
          ofl_d   = ofl_calc;
          zero_d  = (d_fin == 16'h0000);
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          d_d   = d_calc;
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Back-to-back: the result leaves and new operands load on the
            // same edge. D and the flags hold until the new slices overwrite
            // them.
            a_d      = A;
            b_d      = B;
            borrow_d = B_in;
            idx_d    = '0;
            state_d  = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset also discards a calculation in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ofl_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      ofl_q    <= ofl_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_sub_16b_seq.sv
module tb_sub_16b_seq;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: DIGIT=4, instance 1: DIGIT=8, instance 2: DIGIT=16
  logic        iv   [3];
  logic        ir   [3];
  logic [15:0] a    [3];
  logic [15:0] b    [3];
  logic        bin  [3];
  logic [15:0] d    [3];
  logic        bo   [3];
  logic        of   [3];
  logic        zr   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [1:0]  st   [3];

  int total = 0;
  int bad   = 0;

  // Each entry is {D, B_out, Ofl, Zero}.
  logic [18:0] exp_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    sub_16b_seq #(.DIGIT(DG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv[g]),
      .in_ready   (ir[g]),
      .A          (a[g]),
      .B          (b[g]),
      .B_in       (bin[g]),
      .D          (d[g]),
      .B_out      (bo[g]),
      .Ofl        (of[g]),
      .Zero       (zr[g]),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .dbg_state_o(st[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  // Reference model: a full-width unsigned subtract and the signed overflow
  // rule, with an optional clamp.
  function automatic logic [18:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic bi);
    logic [16:0] full;
    logic [15:0] dv;
    logic        ofl;
    full = {1'b0, av} - {1'b0, bv} - {16'h0000, bi};
    dv   = full[15:0];
    ofl  = (av[15] != bv[15]) && (dv[15] != av[15]);
`ifdef SUB16_SAT_EN
    if (ofl) dv = av[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {dv, full[16], ofl, (dv == 16'h0000)};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [15:0] av, input logic [15:0] bv,
                      input logic bi);
    int w;
    w = 0;
    while (!ir[i] && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (ir[i] !== 1'b1) begin
      bad++;
      $display("FAIL send_ready inst=%0d got in_ready=%b want=1", i, ir[i]);
    end
    iv[i]  = 1'b1;
    a[i]   = av;
    b[i]   = bv;
    bin[i] = bi;
    exp_q.push_back(model(av, bv, bi));
    tick();
    // Scramble the operands after the accept edge. They must be ignored.
    iv[i]  = 1'b0;
    a[i]   = 16'($urandom);
    b[i]   = 16'($urandom);
    bin[i] = 1'($urandom_range(0, 1));
  endtask

  // Call this right after send(): it counts cycles from the accept edge.
  task automatic collect(input int i, input string tag);
    int          lat;
    logic [18:0] e;
    logic [18:0] got;
    lat = 0;
    while (ov[i] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat != lat_of(i)) begin
      bad++;
      $display("FAIL %s_latency inst=%0d got=%0d want=%0d", tag, i, lat, lat_of(i));
    end
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
    got = {d[i], bo[i], of[i], zr[i]};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s_result inst=%0d got D=%h Bo=%b O=%b Z=%b want D=%h Bo=%b O=%b Z=%b",
               tag, i, got[18:3], got[2], got[1], got[0], e[18:3], e[2], e[1], e[0]);
    end
    ordy[i] = 1'b1;
    tick();
    total++;
    if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
      bad++;
      $display("FAIL %s_release inst=%0d got out_valid=%b in_ready=%b want 0/1",
               tag, i, ov[i], ir[i]);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; a[i] = '0; b[i] = '0; bin[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ov[i], d[i], bo[i], of[i], zr[i], ir[i], st[i]} !== {1'b0, 16'h0, 3'b000, 1'b1, 2'd0}) begin
        bad++;
        $display("FAIL reset inst=%0d got ov=%b D=%h Bo=%b O=%b Z=%b ir=%b st=%0d want 0/0000/0/0/0/1/0",
                 i, ov[i], d[i], bo[i], of[i], zr[i], ir[i], st[i]);
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    send(0, 16'h1234, 16'h0234, 1'b0); collect(0, "basic");
    send(0, 16'h0000, 16'h0001, 1'b0); collect(0, "wrap");
    send(0, 16'h0005, 16'h0005, 1'b1); collect(0, "bin");
    send(0, 16'h5A5A, 16'h5A5A, 1'b0); collect(0, "zero");
    send(0, 16'h8000, 16'h0001, 1'b0); collect(0, "ofl_neg");
    send(0, 16'h7FFF, 16'hFFFF, 1'b0); collect(0, "ofl_pos");
    send(0, 16'hFFFF, 16'h0000, 1'b1); collect(0, "bin_only");
  endtask

  task automatic test_back_to_back();
    logic [18:0] e;
    logic [18:0] got;
    int          lat;
    ordy[0] = 1'b0;
    send(0, 16'h1234, 16'h0234, 1'b0);
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=4", lat);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
    for (int c = 0; c < 4; c++) begin
      got = {d[0], bo[0], of[0], zr[0]};
      total++;
      if (got !== e || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got res=%h ov=%b ir=%b want res=%h ov=1 ir=0",
                 c, got, ov[0], ir[0], e);
      end
      if (c < 3) tick();
    end
    // Release the result and offer new operands on the same edge.
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    a[0]    = 16'h0010;
    b[0]    = 16'h0001;
    bin[0]  = 1'b0;
    #1;
    total++;
    if (ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready got in_ready=%b want=1", ir[0]);
    end
    exp_q.push_back(model(16'h0010, 16'h0001, 1'b0));
    tick();
    iv[0] = 1'b0;
    total++;
    if (st[0] !== 2'd1 || ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_state got st=%0d ov=%b want st=1 ov=0", st[0], ov[0]);
    end
    collect(0, "b2b");
  endtask

  task automatic test_reset_mid();
    send(0, 16'h1234, 16'h0234, 1'b0);
    // This result will be discarded, so its expectation comes off again.
    void'(exp_q.pop_back());
    tick();            // first CALC edge
    rst = 1'b0;
    tick();            // reset edge during the second CALC cycle
    rst = 1'b1;
    total++;
    if (ov[0] !== 1'b0 || d[0] !== 16'h0000 || ir[0] !== 1'b1 || st[0] !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset got ov=%b D=%h ir=%b st=%0d want 0/0000/1/0",
               ov[0], d[0], ir[0], st[0]);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (ov[0] !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_emit cycle=%0d got out_valid=%b want=0", c, ov[0]);
      end
    end
  endtask

  task automatic test_digits();
    for (int i = 1; i < 3; i++) begin
      send(i, 16'h1234, 16'h0234, 1'b0); collect(i, "dig_basic");
      send(i, 16'h0000, 16'h0001, 1'b0); collect(i, "dig_wrap");
      send(i, 16'h0005, 16'h0005, 1'b1); collect(i, "dig_bin");
      send(i, 16'h7FFF, 16'hFFFF, 1'b0); collect(i, "dig_ofl");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int i;
      i = n % 3;
      send(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      collect(i, "rand");
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_digits();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
